// File: rtl/fifo_dest_demux.sv
// Pop stage behind the ingress FIFO: routes each word by its destination field to one of
// NUM_DEST egress FIFOs, holding one word while that egress is paused. Optional DEMUX_COUNT_EN adds per-destination push counters.
module fifo_dest_demux #(
    parameter int  DATA_SIZE = 10,
    parameter int  DEST_BITS = 2,
    parameter int  CNT_W     = 5,
    localparam int NUM_DEST  = 1 << DEST_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fifo_empty,
    input  logic                 fifo_error,
    input  logic [DATA_SIZE-1:0] data_out_pop,
    output logic                 read,
    input  logic [NUM_DEST-1:0]  pause_in,
    output logic [NUM_DEST-1:0]  push,
    output logic [DATA_SIZE-1:0] data_out,
    output logic                 demux_error
`ifdef DEMUX_COUNT_EN
    ,
    output logic [NUM_DEST*CNT_W-1:0] dest_count
`endif
);

    if (DEST_BITS < 1 || DEST_BITS >= DATA_SIZE || CNT_W < 1) begin : g_bad_params
        $error("fifo_dest_demux: invalid DATA_SIZE/DEST_BITS/CNT_W combination");
    end

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t               state, state_next;
    logic                 pending;
    logic [DATA_SIZE-1:0] hold, hold_next;
    logic [DATA_SIZE-1:0] data_next;
    logic [NUM_DEST-1:0]  push_next;
    logic                 error_next;
    logic [DEST_BITS-1:0] pop_dest, hold_dest;

    assign pop_dest  = data_out_pop[DATA_SIZE-1 -: DEST_BITS];
    assign hold_dest = hold[DATA_SIZE-1 -: DEST_BITS];

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_next = state;
        hold_next  = hold;
        data_next  = data_out;
        push_next  = '0;
        error_next = demux_error | fifo_error;
        read       = 1'b0;

        unique case (state)
            RUN: begin
                // A word about to stall must not be followed by another pop: one word in flight at most.
                read = !fifo_empty && !(pending && pause_in[pop_dest]);
                if (pending) begin
                    if (!pause_in[pop_dest]) begin
                        push_next[pop_dest] = 1'b1;
                        data_next           = data_out_pop;
                    end else begin
                        hold_next  = data_out_pop;
                        state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                if (pending) begin
                    error_next = 1'b1;
                end
                if (!pause_in[hold_dest]) begin
                    push_next[hold_dest] = 1'b1;
                    data_next            = hold;
                    state_next           = RUN;
                end
            end
            default: state_next = RUN;
        endcase

        if (!reset) begin
            read = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= RUN;
            pending     <= 1'b0;
            hold        <= '0;
            push        <= '0;
            data_out    <= '0;
            demux_error <= 1'b0;
        end else begin
            state       <= state_next;
            pending     <= read;
            hold        <= hold_next;
            push        <= push_next;
            data_out    <= data_next;
            demux_error <= error_next;
        end
    end

`ifdef DEMUX_COUNT_EN
    logic [CNT_W-1:0] count [NUM_DEST];

    for (genvar d = 0; d < NUM_DEST; d++) begin : g_count
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                count[d] <= '0;
            end else if (push[d]) begin
                count[d] <= count[d] + CNT_W'(1);
            end
        end
        assign dest_count[d*CNT_W +: CNT_W] = count[d];
    end
`endif

endmodule

// File: tb/tb_fifo_dest_demux.sv
// Scoreboard bench for fifo_dest_demux: an ingress FIFO model feeds directed words, a monitor
// pops expected {push, data} pairs whenever push is non-zero. Define DEMUX_COUNT_EN to cover the counters.
module tb_fifo_dest_demux;

    localparam int DATA_SIZE = 10;
    localparam int DEST_BITS = 2;
    localparam int CNT_W     = 5;
    localparam int NUM_DEST  = 4;

    typedef struct packed {
        logic [NUM_DEST-1:0]  push;
        logic [DATA_SIZE-1:0] data;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 fifo_empty;
    logic                 fifo_error;
    logic [DATA_SIZE-1:0] data_out_pop;
    logic                 read;
    logic [NUM_DEST-1:0]  pause_in;
    logic [NUM_DEST-1:0]  push;
    logic [DATA_SIZE-1:0] data_out;
    logic                 demux_error;
`ifdef DEMUX_COUNT_EN
    logic [NUM_DEST*CNT_W-1:0] dest_count;
`endif

    int checks = 0;
    int errors = 0;

    logic [DATA_SIZE-1:0] ing_q[$];
    exp_t                 sb_q[$];
    logic                 gate = 1'b0;

    fifo_dest_demux #(
        .DATA_SIZE(DATA_SIZE),
        .DEST_BITS(DEST_BITS),
        .CNT_W    (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .fifo_empty  (fifo_empty),
        .fifo_error  (fifo_error),
        .data_out_pop(data_out_pop),
        .read        (read),
        .pause_in    (pause_in),
        .push        (push),
        .data_out    (data_out),
        .demux_error (demux_error)
`ifdef DEMUX_COUNT_EN
        ,
        .dest_count  (dest_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Ingress FIFO model: read data appears the cycle after the pop request.
    always @(posedge clk) begin
        if (reset && read) begin
            if (ing_q.size() > 0) begin
                data_out_pop <= ing_q.pop_front();
            end else begin
                check("read_while_empty", 32'(read), 32'd0);
            end
        end
    end

    // Monitor: every non-zero push must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset && push != '0) begin
            if (sb_q.size() == 0) begin
                check("unexpected_push", 32'(push), 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_push", 32'(push), 32'(e.push));
                check("sb_data", 32'(data_out), 32'(e.data));
            end
        end
    end

    task automatic update_empty();
        fifo_empty = (ing_q.size() == 0) || gate;
        #1;
    endtask

    task automatic step();
        @(negedge clk);
        update_empty();
    endtask

    task automatic send(input logic [DATA_SIZE-1:0] w);
        exp_t e;
        e.push = NUM_DEST'(1) << w[DATA_SIZE-1 -: DEST_BITS];
        e.data = w;
        ing_q.push_back(w);
        sb_q.push_back(e);
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        check(name, 32'(sb_q.size()), 32'd0);
    endtask

    logic [3:0] t2_push [5] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset      = 1'b0;
        fifo_empty = 1'b1;
        fifo_error = 1'b0;
        pause_in   = '0;
        data_out_pop = '0;

        // 1: reset with a non-empty ingress FIFO
        send(10'h003); send(10'h104); send(10'h205); send(10'h306);
        repeat (2) @(negedge clk);
        update_empty();
        check("rst_read",  32'(read), 32'd0);
        check("rst_push",  32'(push), 32'd0);
        check("rst_data",  32'(data_out), 32'd0);
        check("rst_error", 32'(demux_error), 32'd0);
        reset = 1'b1;
        #1;
        check("release_read", 32'(read), 32'd1);

        // 2: back-to-back stream, two-cycle latency
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("t2_push_%0d", i), 32'(push), 32'(t2_push[i]));
        end
        drain("t2_drain", 10);
        repeat (2) step();

        // 3: paused destination forces HOLD, then releases
        send(10'h104); send(10'h007);
        pause_in = 4'b0010;
        update_empty();
        check("t3_read_start", 32'(read), 32'd1);
        step();
        check("t3_read_stall", 32'(read), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("t3_hold_read_%0d", i), 32'(read), 32'd0);
            check($sformatf("t3_hold_push_%0d", i), 32'(push), 32'd0);
        end
        pause_in = 4'b0000;
        #1;
        check("t3_read_unpaused_hold", 32'(read), 32'd0);
        step();
        check("t3_push", 32'(push), 32'b0010);
        check("t3_data", 32'(data_out), 32'h104);
        check("t3_resume_read", 32'(read), 32'd1);
        drain("t3_drain", 10);
        repeat (2) step();

        // 4: pause on another destination does not block dest 0
        pause_in = 4'b0010;
        send(10'h003); send(10'h00A);
        update_empty();
        step();
        check("t4_push_0", 32'(push), 32'd0);
        step();
        check("t4_push_1", 32'(push), 32'b0001);
        step();
        check("t4_push_2", 32'(push), 32'b0001);
        check("t4_data_2", 32'(data_out), 32'h00A);
        drain("t4_drain", 5);
        pause_in = 4'b0000;
        repeat (2) step();

        // 5: ingress empty toggling every cycle, then error pulse
        send(10'h1FF); send(10'h2AA); send(10'h055); send(10'h3C3);
        for (int i = 0; i < 30 && sb_q.size() != 0; i++) begin
            gate = ~gate;
            step();
        end
        gate = 1'b0;
        check("t5_drain", 32'(sb_q.size()), 32'd0);
        repeat (3) step();
        check("t5_error_clear", 32'(demux_error), 32'd0);
        fifo_error = 1'b1;
        step();
        fifo_error = 1'b0;
        check("t5_error_set", 32'(demux_error), 32'd1);
        repeat (3) step();
        check("t5_error_sticky", 32'(demux_error), 32'd1);

        // 6: reset while holding a word drops it
        pause_in = 4'b0100;
        send(10'h2F0);
        update_empty();
        step();
        step();
        check("t6_hold_push", 32'(push), 32'd0);
        check("t6_hold_read", 32'(read), 32'd0);
        reset = 1'b0;
        #1;
        sb_q.delete();
        check("t6_rst_push",  32'(push), 32'd0);
        check("t6_rst_data",  32'(data_out), 32'd0);
        check("t6_rst_error", 32'(demux_error), 32'd0);
        check("t6_rst_read",  32'(read), 32'd0);
        pause_in = 4'b0000;
        repeat (2) step();
        reset = 1'b1;
        repeat (5) step();
        check("t6_no_leak_data", 32'(data_out), 32'd0);

`ifdef DEMUX_COUNT_EN
        // 33 pushes to dest 2 wrap its 5-bit counter to 1
        check("cnt_reset", 32'(dest_count), 32'd0);
        for (int i = 0; i < 33; i++) begin
            send(10'h200 | 10'(i));
        end
        update_empty();
        drain("cnt_drain", 80);
        repeat (2) step();
        check("cnt_dest2", 32'(dest_count), 32'h400);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
